bit_serial_adder: RTL
=====================

# bit_serial_adder

Multi-cycle adder for WIDTH-bit operands, one bit per clock, LSB first. It reuses the team's two-half-adder `fa` cell as its only arithmetic element, with a registered carry. It sits around `fa`: it supplies `fa` with `a`, `b` and `cin` each cycle and consumes its `s1` and `c2`. It is the area-minimal adder for slow control paths.

## Interface
- `WIDTH`, default 8: operand and sum width in bits, must be ≥ 2.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset; one clock, asynchronous, active-low.
- `start`  in  1  request pulse; operands are sampled when it is accepted.
- `a_in`  in  WIDTH  operand A, unsigned or two's complement.
- `b_in`  in  WIDTH  operand B.
- `cin_in`  in  1  carry-in for bit 0.
- `busy`  out  1  high while bits are being processed.
- `done`  out  1  one-cycle pulse when `sum` and `cout` become valid.
- `sum`  out  WIDTH  result, held until the next accepted `start`.
- `cout`  out  1  carry out of bit WIDTH-1, held with `sum`.

## Operation
- Internal state: shift registers `a_sh` and `b_sh` (WIDTH bits each), `s_sh` (WIDTH bits), a carry flop, and a bit counter of width $clog2(WIDTH+1).
- FSM has three states.
  - IDLE:
    - `start`=1 → load `a_sh`=`a_in`, `b_sh`=`b_in`, carry=`cin_in`, counter=0.
    - Go to RUN.
  - RUN, each cycle:
    - Drive one `fa` instance with `a_sh[0]`, `b_sh[0]` and carry.
    - Right-shift `a_sh` and `b_sh`.
    - Shift `fa.s1` into the MSB of `s_sh` (right shift).
    - carry ← `fa.c2`; counter += 1.
    - When counter reaches WIDTH-1 in this cycle, go to DONE.
  - DONE, single cycle:
    - `done`=1.
    - `sum` = `s_sh`, `cout` = carry.
    - `start`=1 is accepted exactly as in IDLE and goes to RUN; otherwise go to IDLE.
- `start` in RUN is ignored. It is not queued.
- `sum`/`cout` are output registers updated only on entry to DONE. They are not disturbed during a following RUN.
- Arithmetic is modulo 2^WIDTH; `cout` = bit WIDTH of a_in+b_in+cin_in.

## Timing
- Reset values: `busy`=0, `done`=0, `sum`=0, `cout`=0, FSM=IDLE, all internal registers 0.
- `start` is sampled at rising edge T → `busy`=1 from T through T+WIDTH (WIDTH cycles).
- At edge T+WIDTH: `done`=1, `sum`/`cout` are valid, and `busy`=0 for that cycle.
- Latency from start edge to done is WIDTH+1 edges, measured start-edge to done-falling edge; throughput is one add per WIDTH+1 cycles.
- Back-to-back: `start` held high during DONE → the new RUN begins at the next edge. `busy` then rises on the edge after `done`.
- `rst_n` low at any time, including mid-RUN:
  - Outputs go to their reset values immediately.
  - The partial result is discarded.
  - After release, the block waits in IDLE for a fresh `start`.
- `start` coincident with `rst_n` release edge: ignored.

## Configuration
- Macro `BIT_SERIAL_ADDER_OVF_EN`.
- Defined:
  - Adds output `ovf` (1 bit) for signed overflow: carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
  - `ovf` is registered with `sum`, is valid in DONE, is held afterwards, and resets to 0.
- Undefined: the `ovf` port and its logic are absent; all other behaviour is identical.

## Test plan
- WIDTH=8, `a_in`=0x5A, `b_in`=0x3C, `cin_in`=0, one-cycle `start` → `busy` high for 8 cycles; `done` pulses once; `sum`=0x96, `cout`=0.
- `a_in`=0xFF, `b_in`=0x01, `cin_in`=0 → `sum`=0x00, `cout`=1; then `a_in`=0xFF, `b_in`=0xFF, `cin_in`=1 → `sum`=0xFF, `cout`=1.
- `start` pulsed again at cycle 3 of a RUN with different operands → ignored; the result is that of the first operands, and there is only one `done`.
- `start` held high continuously with 0x10+0x20, then 0x01+0x02 presented during DONE → two results 0x30 then 0x03; `done` spacing is 9 cycles; `sum` holds 0x30 during the second RUN.
- `rst_n` asserted at cycle 4 of a RUN → `busy`, `done`, `sum` and `cout` read 0 immediately; no `done` follows release until a new `start`.
- With `BIT_SERIAL_ADDER_OVF_EN`: 0x7F+0x01 → `sum`=0x80, `ovf`=1, `cout`=0; 0x80+0x80 → `sum`=0x00, `ovf`=1, `cout`=1; 0x40+0x20 → `ovf`=0.

Source files
------------

// File: rtl/bit_serial_adder.sv
// Bit-serial adder: one bit per clock, LSB first, around a single two-half-adder fa cell.
// Optional signed-overflow output enabled by defining BIT_SERIAL_ADDER_OVF_EN.

module fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s1,
  output logic c2
);
  logic p, g;

  // First half adder propagates/generates; second folds in the carry.
  assign p  = a ^ b;
  assign g  = a & b;
  assign s1 = p ^ cin;
  assign c2 = g | (p & cin);
endmodule

module bit_serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
`ifdef BIT_SERIAL_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic             cout
);
  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state;
  logic [WIDTH-1:0]  a_sh, b_sh, s_sh;
  logic              carry;
  logic [CntW-1:0]   cnt;
  logic              fa_s, fa_c;

  fa u_fa (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .cin(carry),
    .s1 (fa_s),
    .c2 (fa_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= StIdle;
      a_sh  <= '0;
      b_sh  <= '0;
      s_sh  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
`ifdef BIT_SERIAL_ADDER_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      unique case (state)
        StIdle, StDone: begin
          done <= 1'b0;
          if (start) begin
            a_sh  <= a_in;
            b_sh  <= b_in;
            carry <= cin_in;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= StRun;
          end else begin
            state <= StIdle;
          end
        end
        StRun: begin
          a_sh  <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
          s_sh  <= {fa_s, s_sh[WIDTH-1:1]};
          carry <= fa_c;
          cnt   <= cnt + 1'b1;
          // The last bit's sum goes straight into the output register.
          if (cnt == CntW'(WIDTH - 1)) begin
            state <= StDone;
            busy  <= 1'b0;
            done  <= 1'b1;
            sum   <= {fa_s, s_sh[WIDTH-1:1]};
            cout  <= fa_c;
`ifdef BIT_SERIAL_ADDER_OVF_EN
            ovf   <= carry ^ fa_c;
`endif
          end
        end
        default: state <= StIdle;
      endcase
    end
  end
endmodule
